fetch_unit: RTL

Instruction fetch stage of the single-cycle CPU, directly upstream of the general controller. It holds the program counter and issues one request per instruction to instruction memory over a req/ack handshake. It presents the fetched word to the decode/control stage over a valid/ready handshake. When that stage retires the instruction, the unit computes the next PC from the controller's Branch/Jump decisions.

---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit_npc_calc.sv | 29 ++
 rtl/fetch_unit.sv | 109 ++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, reset PC,
// instruction field positions and PC arithmetic helpers.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] PC_INC       = 32'd4;

  localparam int unsigned IMM16_MSB    = 15;
  localparam int unsigned IMM16_LSB    = 0;
  localparam int unsigned TARGET26_MSB = 25;
  localparam int unsigned TARGET26_LSB = 0;

  function automatic logic [31:0] sext_imm16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory req/ack, decode valid/ready and the
// controller's next-PC decisions.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch;
  logic        br_taken;
  logic        jump;
  logic        jr;
  logic [31:0] jr_target;
  logic        misalign_err;

  modport master (
    output imem_req, imem_addr, instruction, inst_valid, pc, pc_plus4, misalign_err,
    input  imem_ack, imem_rdata, inst_ready, branch, br_taken, jump, jr, jr_target
  );

  modport slave (
    input  imem_req, imem_addr, instruction, inst_valid, pc, pc_plus4, misalign_err,
    output imem_ack, imem_rdata, inst_ready, branch, br_taken, jump, jr, jr_target
  );
endinterface

// File: rtl/fetch_unit_npc_calc.sv
// Combinational next-PC selection: jr > jump > taken branch > sequential.
module npc_calc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instruction,
  input  logic        branch,
  input  logic        br_taken,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] npc
);

  logic unused_opcode;
  assign unused_opcode = ^instruction[31:26];

  always_comb begin
    npc = pc_plus4;
    if (jr) begin
      npc = jr_target;
    end else if (jump) begin
      npc = {pc_plus4[31:28], instruction[TARGET26_MSB:TARGET26_LSB], 2'b00};
    end else if (branch && br_taken) begin
      npc = pc_plus4 + (sext_imm16(instruction[IMM16_MSB:IMM16_LSB]) << 2);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, imem req/ack and decode valid/ready FSM.
// Optional IFU_ALIGN_CHECK_EN traps misaligned next-PC into a terminal error state.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input logic        clk,
  input logic        rst_n,
  fetch_unit_if.master fu
);

  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("fetch_unit: RESET_PC must be word-aligned");
  end

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        req_q;
  logic        valid_q;
  logic [31:0] pc_plus4;
  logic [31:0] npc;

  assign pc_plus4 = pc_q + PC_INC;

  npc_calc u_npc_calc (
    .pc_plus4   (pc_plus4),
    .instruction(inst_q),
    .branch     (fu.branch),
    .br_taken   (fu.br_taken),
    .jump       (fu.jump),
    .jr         (fu.jr),
    .jr_target  (fu.jr_target),
    .npc        (npc)
  );

`ifdef IFU_ALIGN_CHECK_EN
  logic err_q;
  assign fu.misalign_err = err_q;
`else
  logic unused_npc_lo;
  assign unused_npc_lo   = ^npc[1:0];
  assign fu.misalign_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_REQ;
          req_q <= 1'b1;
        end
        S_REQ: begin
          if (fu.imem_ack) begin
            inst_q  <= fu.imem_rdata;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (fu.inst_ready) begin
            valid_q <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
            // pc takes the raw npc even when misaligned so the faulting target is visible
            pc_q <= npc;
            if (npc[1:0] != 2'b00) begin
              state <= S_ERR;
              err_q <= 1'b1;
            end else begin
              state <= S_REQ;
              req_q <= 1'b1;
            end
`else
            pc_q  <= {npc[31:2], 2'b00};
            state <= S_REQ;
            req_q <= 1'b1;
`endif
          end
        end
`ifdef IFU_ALIGN_CHECK_EN
        S_ERR: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  assign fu.imem_req    = req_q;
  assign fu.imem_addr   = pc_q;
  assign fu.instruction = inst_q;
  assign fu.inst_valid  = valid_q;
  assign fu.pc          = pc_q;
  assign fu.pc_plus4    = pc_plus4;

endmodule
